keypad_mode_front_end: RTL and testbench

Keypad front end: takes a 10-key one-hot keypad, synchronises it and encodes the pressed key to BCD plus a key-valid flag. It routes the valid flag to one of two mode lines through a 1:2 demultiplexer. Mode line 0 drives a 3-stage toggle flip-flop divider chain that counts qualifying key presses. The block sits between the raw keypad pins and the mode/sequencing logic of the system.

---
 rtl/keypad_mode_front_end.sv | 106 ++++++++++
 tb/tb_keypad_mode_front_end.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_mode_front_end.sv
// -----------------------------------------------------------------------------
// keypad_mode_front_end
//
// Front end between the raw 10-key one-hot keypad pins and the mode/sequencing
// logic. Synchronises the keypad, priority-encodes the pressed key to BCD,
// routes the key-valid flag to one of two mode lines, and counts rising edges
// of mode line 0 in a 3-stage toggle flip-flop divider chain.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   key        in  10   raw keypad lines (asynchronous to clk), bit i = key i
//   sel        in   1   demux select: 0 -> mode[0], 1 -> mode[1]
//   t          in   1   toggle enable for the divider chain
//   bcd        out  4   BCD code of the highest pressed key (0 when none)
//   key_valid  out  1   at least one synchronised key pressed
//   mode       out  2   demultiplexed key_valid
//   q          out  3   divider chain state, q[0] least significant stage
//   q_n        out  3   bitwise complement of q
// -----------------------------------------------------------------------------
module keypad_mode_front_end (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] key,
  input  logic       sel,
  input  logic       t,
  output logic [3:0] bcd,
  output logic       key_valid,
  output logic [1:0] mode,
  output logic [2:0] q,
  output logic [2:0] q_n
);

  logic [9:0] key_meta;
  logic [9:0] key_s;
  logic       mode0_d;
  logic       press;
  logic [2:0] toggle;

  // Two-flop synchroniser for the asynchronous keypad lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta <= 10'd0;
      key_s    <= 10'd0;
    end else begin
      key_meta <= key;
      key_s    <= key_meta;
    end
  end

  // Priority encoder: the highest-numbered pressed key wins.
  always_comb begin
    bcd = 4'd0;
    casez (key_s)
      10'b1?????????: bcd = 4'd9;
      10'b01????????: bcd = 4'd8;
      10'b001???????: bcd = 4'd7;
      10'b0001??????: bcd = 4'd6;
      10'b00001?????: bcd = 4'd5;
      10'b000001????: bcd = 4'd4;
      10'b0000001???: bcd = 4'd3;
      10'b00000001??: bcd = 4'd2;
      10'b000000001?: bcd = 4'd1;
      10'b0000000001: bcd = 4'd0;
      default:        bcd = 4'd0;
    endcase
  end

  assign key_valid = |key_s;

  // 1:2 demultiplexer of the key-valid flag; the unselected line stays low.
  assign mode[0] = key_valid & ~sel;
  assign mode[1] = key_valid &  sel;

  // Previous value of mode[0] for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode0_d <= 1'b0;
    end else begin
      mode0_d <= mode[0];
    end
  end

  // One pulse per rising edge of mode[0]: a held key, a key change while
  // another key remains pressed, or sel returning to 0 with a key held all
  // behave like the edge they produce on mode[0].
  assign press = mode[0] & ~mode0_d;

  // Synchronous emulation of a ripple T-flip-flop divider: a stage toggles
  // when a qualifying press arrives and every lower stage is already 1.
  assign toggle[0] = press & t;
  assign toggle[1] = toggle[0] & q[0];
  assign toggle[2] = toggle[1] & q[1];

  // Divider chain state; presses while t = 0 are dropped, not queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 3'd0;
    end else begin
      q <= q ^ toggle;
    end
  end

  assign q_n = ~q;

endmodule

// File: tb/tb_keypad_mode_front_end.sv
module tb_keypad_mode_front_end;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] key = 10'd0;
  logic       sel = 1'b0;
  logic       t = 1'b1;
  logic [3:0] bcd;
  logic       key_valid;
  logic [1:0] mode;
  logic [2:0] q;
  logic [2:0] q_n;

  int errors = 0;
  int checks = 0;

  keypad_mode_front_end dut (
    .clk(clk), .rst_n(rst_n), .key(key), .sel(sel), .t(t),
    .bcd(bcd), .key_valid(key_valid), .mode(mode), .q(q), .q_n(q_n)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  // The design sees the key value that was present two clock edges ago.
  // It counts (modulo 8) every edge at which "some key seen and sel = 0"
  // becomes true while t = 1.
  logic [9:0] seen_1, seen_2;
  logic       was_on;
  int         presses;

  function automatic int top_key(input logic [9:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 10; i++) if (v[i]) r = i;
    return r;
  endfunction

  wire m_any = (seen_2 != 10'd0);
  wire m_on  = m_any && !sel;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_1  <= 10'd0;
      seen_2  <= 10'd0;
      was_on  <= 1'b0;
      presses <= 0;
    end else begin
      seen_1 <= key;
      seen_2 <= seen_1;
      was_on <= m_on;
      if (m_on && !was_on && t) presses <= (presses + 1) % 8;
    end
  end

  wire [2:0]  e_q   = 3'(presses);
  wire [12:0] e_all = {4'(top_key(seen_2)), m_any, m_any && sel, m_on, e_q, ~e_q};
  wire [12:0] d_all = {bcd, key_valid, mode, q, q_n};

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic hold_key(input logic [9:0] k, input int cycles);
    @(negedge clk);
    key = k;
    repeat (cycles - 1) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; key = 10'h3FF; sel = 1'b0; t = 1'b1;
    #3;
    checks++; if (bcd !== 4'd0) begin errors++; $display("FAIL reset_bcd: got %0d want 0", bcd); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_kv: got %b want 0", key_valid); end
    checks++; if (mode !== 2'b00) begin errors++; $display("FAIL reset_mode: got %b want 00", mode); end
    checks++; if ({q, q_n} !== 6'b000_111) begin errors++; $display("FAIL reset_q: got q=%b q_n=%b want 000/111", q, q_n); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_lat1: got kv=%b want 0 after one edge", key_valid); end
    @(posedge clk); #1;
    checks++; if ({bcd, key_valid} !== 5'b1001_1) begin errors++; $display("FAIL reset_prio: got bcd=%b kv=%b want 1001/1", bcd, key_valid); end
    hold_key(10'd0, 5);
    pulse_reset();
    @(negedge clk);
    checks++; if (d_all !== e_all) begin errors++; $display("FAIL reset_model: got %h want %h", d_all, e_all); end
  endtask

  task automatic test_single_press();
    sel = 1'b0; t = 1'b1;
    @(negedge clk); key = 10'd1;
    @(posedge clk); @(posedge clk); #1;
    checks++; if ({bcd, key_valid, mode, q} !== {4'd0, 1'b1, 2'b01, 3'd0}) begin
      errors++; $display("FAIL single_lat2: got bcd=%0d kv=%b mode=%b q=%0d want 0/1/01/0", bcd, key_valid, mode, q); end
    @(posedge clk); #1;
    checks++; if (q !== 3'd1) begin errors++; $display("FAIL single_lat3: got q=%0d want 1", q); end
    repeat (3) @(negedge clk);
    key = 10'd0;
    repeat (5) @(negedge clk);
    checks++; if ({q, q_n} !== {3'd1, 3'd6}) begin errors++; $display("FAIL single_once: got q=%0d q_n=%b want 1/110", q, q_n); end
    checks++; if (d_all !== e_all) begin errors++; $display("FAIL single_model: got %h want %h", d_all, e_all); end
  endtask

  task automatic test_sequence();
    logic [9:0] ks [3];
    logic [3:0] want_bcd [3];
    ks = '{10'h002, 10'h200, 10'h080};
    want_bcd = '{4'd1, 4'd9, 4'd7};
    pulse_reset();
    sel = 1'b0; t = 1'b1;
    for (int i = 0; i < 3; i++) begin
      hold_key(ks[i], 5);
      checks++; if (bcd !== want_bcd[i]) begin errors++; $display("FAIL seq_bcd%0d: got %b want %b", i, bcd, want_bcd[i]); end
      checks++; if ({q, q_n} !== {3'(i + 1), ~3'(i + 1)}) begin errors++; $display("FAIL seq_q%0d: got q=%b q_n=%b want %0d", i, q, q_n, i + 1); end
      hold_key(10'd0, 5);
      checks++; if (d_all !== e_all) begin errors++; $display("FAIL seq_model%0d: got %h want %h", i, d_all, e_all); end
    end
  endtask

  task automatic test_routing();
    sel = 1'b1; t = 1'b1;
    hold_key(10'h008, 5);
    checks++; if ({bcd, mode, q} !== {4'd3, 2'b10, 3'd3}) begin
      errors++; $display("FAIL route_sel1: got bcd=%0d mode=%b q=%0d want 3/10/3", bcd, mode, q); end
    hold_key(10'd0, 5);
    sel = 1'b0; t = 1'b0;
    hold_key(10'h008, 5);
    checks++; if ({bcd, mode, q} !== {4'd3, 2'b01, 3'd3}) begin
      errors++; $display("FAIL route_t0: got bcd=%0d mode=%b q=%0d want 3/01/3", bcd, mode, q); end
    hold_key(10'd0, 5);
    t = 1'b1;
    @(negedge clk);
    checks++; if (q !== 3'd3) begin errors++; $display("FAIL route_lost: got q=%0d want 3", q); end
    // sel 1->0 with key held counts; 0->1 does not.
    sel = 1'b1;
    hold_key(10'h010, 5);
    sel = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (q !== 3'd4) begin errors++; $display("FAIL route_selfall: got q=%0d want 4", q); end
    sel = 1'b1;
    repeat (3) @(negedge clk);
    sel = 1'b0;
    hold_key(10'd0, 1);
    repeat (3) @(negedge clk);
    checks++; if (d_all !== e_all) begin errors++; $display("FAIL route_model: got %h want %h", d_all, e_all); end
  endtask

  task automatic test_wrap();
    pulse_reset();
    sel = 1'b0; t = 1'b1;
    for (int i = 0; i < 8; i++) begin
      hold_key(10'd1 << $urandom_range(0, 9), 3 + $urandom_range(0, 3));
      hold_key(10'd0, 3 + $urandom_range(0, 3));
      checks++; if (q !== 3'((i + 1) % 8)) begin errors++; $display("FAIL wrap_q%0d: got %0d want %0d", i, q, (i + 1) % 8); end
    end
    checks++; if (q_n !== 3'b111) begin errors++; $display("FAIL wrap_qn: got %b want 111", q_n); end
    hold_key(10'h040, 20);
    hold_key(10'h240, 5);
    hold_key(10'd0, 5);
    checks++; if (q !== 3'd1) begin errors++; $display("FAIL wrap_hold: got %0d want 1", q); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [9:0] k;
      int hold;
      k = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom);
      hold = 3 + $urandom_range(0, 4);
      @(negedge clk);
      key = k;
      sel = 1'($urandom);
      t = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        if ($urandom_range(0, 5) == 0) sel = ~sel;
        checks++; if (d_all !== e_all) begin errors++; $display("FAIL rand_%0d_%0d: got %h want %h", n, c, d_all, e_all); end
      end
    end
    key = 10'd0; sel = 1'b0; t = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_async_reset();
    pulse_reset();
    sel = 1'b0; t = 1'b1;
    repeat (5) begin
      hold_key(10'h020, 4);
      hold_key(10'd0, 4);
    end
    checks++; if (q !== 3'b101) begin errors++; $display("FAIL async_pre: got q=%b want 101", q); end
    hold_key(10'h020, 4);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++; if ({q, q_n, mode} !== {3'b000, 3'b111, 2'b00}) begin
      errors++; $display("FAIL async_now: got q=%b q_n=%b mode=%b want 000/111/00", q, q_n, mode); end
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if ({q, mode} !== {3'd1, 2'b01}) begin errors++; $display("FAIL async_repress: got q=%0d mode=%b want 1/01", q, mode); end
    checks++; if (d_all !== e_all) begin errors++; $display("FAIL async_model: got %h want %h", d_all, e_all); end
    key = 10'd0;
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_sequence();
    test_routing();
    test_wrap();
    test_random();
    test_async_reset();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
